// File: rtl/wb_interconnect_nx.sv
// Wishbone classic 1-master / N-slave interconnect with a registered request and response,
// an error response for unmapped slots and an optional per-transaction ack timeout.
module wb_interconnect_nx #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 32,
  parameter int unsigned SLV_AW     = 9,
  parameter int unsigned DEC_LSB    = 12,
  parameter int unsigned DEC_W      = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_n,
  input  logic [DW-1:0]                  m0_wb_dat_i,
  input  logic [AW-1:0]                  m0_wb_adr_i,
  input  logic [DW/8-1:0]                m0_wb_sel_i,
  input  logic                           m0_wb_we_i,
  input  logic                           m0_wb_cyc_i,
  input  logic                           m0_wb_stb_i,
  output logic [DW-1:0]                  m0_wb_dat_o,
  output logic                           m0_wb_ack_o,
  output logic                           m0_wb_err_o,
  input  logic [NUM_SLAVES*DW-1:0]       s_wb_dat_i,
  input  logic [NUM_SLAVES-1:0]          s_wb_ack_i,
  output logic [NUM_SLAVES*DW-1:0]       s_wb_dat_o,
  output logic [NUM_SLAVES*SLV_AW-1:0]   s_wb_adr_o,
  output logic [NUM_SLAVES*(DW/8)-1:0]   s_wb_sel_o,
  output logic [NUM_SLAVES-1:0]          s_wb_we_o,
  output logic [NUM_SLAVES-1:0]          s_wb_cyc_o,
  output logic [NUM_SLAVES-1:0]          s_wb_stb_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DEC_W-1:0]  tid_q, tid_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [SLV_AW-1:0] adr_q, adr_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic              we_q, we_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     rdat_q, rdat_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  logic [DEC_W-1:0]  dec_tid;
  logic              mapped;
  logic              req_valid;
  logic              timeout_hit;
  logic              sel_ack;
  logic [DW-1:0]     sel_dat;
  logic              unused_adr;

  assign dec_tid     = m0_wb_adr_i[DEC_LSB +: DEC_W];
  assign mapped      = 32'(dec_tid) < NUM_SLAVES;
  assign req_valid   = m0_wb_cyc_i & m0_wb_stb_i;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
  // Only the slave word address and the select field matter; the rest of the address is ignored.
  assign unused_adr  = ^m0_wb_adr_i;

  // Response mux: only the latched target's ack and data are ever looked at.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (32'(tid_q) == k) begin
        sel_ack = s_wb_ack_i[k];
        sel_dat = s_wb_dat_i[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tid_d   = tid_q;
    dat_d   = dat_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (mapped) begin
            state_d = StReq;
            tid_d   = dec_tid;
            dat_d   = m0_wb_dat_i;
            adr_d   = m0_wb_adr_i[SLV_AW+1:2];
            sel_d   = m0_wb_sel_i;
            we_d    = m0_wb_we_i;
            cnt_d   = '0;
          end else begin
            state_d = StResp;
            err_d   = 1'b1;
            rdat_d  = '0;
          end
        end
      end
      StReq: begin
        // Abort beats a simultaneous ack; ack beats a simultaneous timeout.
        if (!req_valid) begin
          state_d = StIdle;
        end else if (sel_ack) begin
          state_d = StResp;
          ack_d   = 1'b1;
          rdat_d  = sel_dat;
        end else if (timeout_hit) begin
          state_d = StResp;
          err_d   = 1'b1;
          rdat_d  = '0;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tid_q   <= '0;
      dat_q   <= '0;
      adr_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tid_q   <= tid_d;
      dat_q   <= dat_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Non-selected slaves see an all-zero bundle, and every slave is idle outside StReq.
  always_comb begin
    s_wb_dat_o = '0;
    s_wb_adr_o = '0;
    s_wb_sel_o = '0;
    s_wb_we_o  = '0;
    s_wb_cyc_o = '0;
    s_wb_stb_o = '0;
    if (state_q == StReq) begin
      for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
        if (32'(tid_q) == k) begin
          s_wb_dat_o[k*DW +: DW]         = dat_q;
          s_wb_adr_o[k*SLV_AW +: SLV_AW] = adr_q;
          s_wb_sel_o[k*SW +: SW]         = sel_q;
          s_wb_we_o[k]                   = we_q;
          s_wb_cyc_o[k]                  = 1'b1;
          s_wb_stb_o[k]                  = 1'b1;
        end
      end
    end
  end

  assign m0_wb_dat_o = rdat_q;
  assign m0_wb_ack_o = ack_q;
  assign m0_wb_err_o = err_q;

endmodule

// File: tb/tb_wb_interconnect_nx.sv
// Bench for wb_interconnect_nx: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized master/slave traffic.
module tb_wb_interconnect_nx;

  localparam int unsigned NS  = 3;
  localparam int unsigned TO  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned SAW = 9;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;

  logic [DW-1:0]      m_dat;
  logic [31:0]        m_adr;
  logic [3:0]         m_sel;
  logic               m_we, m_cyc, m_stb;
  logic [DW-1:0]      m_dat_o;
  logic               m_ack_o, m_err_o;
  logic [NS*DW-1:0]   s_dat_i;
  logic [NS-1:0]      s_ack_i;
  logic [NS*DW-1:0]   s_dat_o;
  logic [NS*SAW-1:0]  s_adr_o;
  logic [NS*4-1:0]    s_sel_o;
  logic [NS-1:0]      s_we_o, s_cyc_o, s_stb_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one outstanding transaction described by its target and strobed-cycle age.
  bit          md_active;
  int          md_tid;
  int          md_strobed;
  int          md_resp;      // 0 none, 1 ack, 2 err
  logic [31:0] md_last;
  logic [31:0] md_dat;
  logic [8:0]  md_adr;
  logic [3:0]  md_sel;
  logic        md_we;

  wb_interconnect_nx #(
    .NUM_SLAVES (NS),
    .DW         (DW),
    .AW         (32),
    .SLV_AW     (SAW),
    .DEC_LSB    (12),
    .DEC_W      (2),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .m0_wb_dat_i (m_dat),
    .m0_wb_adr_i (m_adr),
    .m0_wb_sel_i (m_sel),
    .m0_wb_we_i  (m_we),
    .m0_wb_cyc_i (m_cyc),
    .m0_wb_stb_i (m_stb),
    .m0_wb_dat_o (m_dat_o),
    .m0_wb_ack_o (m_ack_o),
    .m0_wb_err_o (m_err_o),
    .s_wb_dat_i  (s_dat_i),
    .s_wb_ack_i  (s_ack_i),
    .s_wb_dat_o  (s_dat_o),
    .s_wb_adr_o  (s_adr_o),
    .s_wb_sel_o  (s_sel_o),
    .s_wb_we_o   (s_we_o),
    .s_wb_cyc_o  (s_cyc_o),
    .s_wb_stb_o  (s_stb_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    md_active  = 1'b0;
    md_tid     = 0;
    md_strobed = 0;
    md_resp    = 0;
    md_last    = '0;
    md_dat     = '0;
    md_adr     = '0;
    md_sel     = '0;
    md_we      = 1'b0;
  endtask

  task automatic model_edge();
    int t;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (md_resp != 0) begin
      md_resp = 0;
      return;
    end
    if (md_active) begin
      if (!(m_cyc && m_stb)) begin
        md_active = 1'b0;
      end else if (s_ack_i[md_tid]) begin
        md_active = 1'b0;
        md_resp   = 1;
        md_last   = s_dat_i[md_tid*DW +: DW];
      end else begin
        md_strobed++;
        if (TO != 0 && md_strobed == int'(TO)) begin
          md_active = 1'b0;
          md_resp   = 2;
          md_last   = '0;
        end
      end
      return;
    end
    if (m_cyc && m_stb) begin
      t = int'(m_adr[13:12]);
      if (t < int'(NS)) begin
        md_active  = 1'b1;
        md_tid     = t;
        md_strobed = 0;
        md_dat     = m_dat;
        md_adr     = m_adr[10:2];
        md_sel     = m_sel;
        md_we      = m_we;
      end else begin
        md_resp = 2;
        md_last = '0;
      end
    end
  endtask

  task automatic check_all();
    logic [NS*DW-1:0]  e_dat;
    logic [NS*SAW-1:0] e_adr;
    logic [NS*4-1:0]   e_sel;
    logic [NS-1:0]     e_we, e_cyc;
    e_dat = '0;
    e_adr = '0;
    e_sel = '0;
    e_we  = '0;
    e_cyc = '0;
    if (md_active) begin
      e_cyc[md_tid]               = 1'b1;
      e_we[md_tid]                = md_we;
      e_dat[md_tid*DW +: DW]      = md_dat;
      e_adr[md_tid*SAW +: SAW]    = md_adr;
      e_sel[md_tid*4 +: 4]        = md_sel;
    end
    chk("s_cyc", s_cyc_o, e_cyc);
    chk("s_stb", s_stb_o, e_cyc);
    chk("s_we", s_we_o, e_we);
    chk("s_dat", s_dat_o, e_dat);
    chk("s_adr", s_adr_o, e_adr);
    chk("s_sel", s_sel_o, e_sel);
    chk("m_ack", m_ack_o, md_resp == 1);
    chk("m_err", m_err_o, md_resp == 2);
    chk("m_dat", m_dat_o, md_last);
  endtask

  always @(negedge clk_i) check_all();

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic req(input logic [31:0] adr, input logic [31:0] dat, input logic we);
    m_adr = adr;
    m_dat = dat;
    m_sel = 4'hF;
    m_we  = we;
    m_cyc = 1'b1;
    m_stb = 1'b1;
  endtask

  task automatic drop();
    m_cyc = 1'b0;
    m_stb = 1'b0;
  endtask

  initial begin
    int stb_cnt;
    m_dat = '0; m_adr = '0; m_sel = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
    s_dat_i = '0; s_ack_i = '0;
    model_reset();
    repeat (3) tick();
    chk("rst_cyc", s_cyc_o, '0);
    chk("rst_mdat", m_dat_o, '0);
    rst_n = 1'b1;
    tick();
    chk("idle_ack", {m_ack_o, m_err_o}, 2'b00);

    // Write to slave 1, slave acks on its third strobed cycle
    req(32'h0000_1008, 32'hA5A5_1234, 1'b1);
    tick();
    chk("wr_cyc", s_cyc_o, 3'b010);
    chk("wr_we", s_we_o, 3'b010);
    chk("wr_adr", s_adr_o, {9'h000, 9'h002, 9'h000});
    chk("wr_dat", s_dat_o, {32'h0, 32'hA5A5_1234, 32'h0});
    chk("wr_sel", s_sel_o, {4'h0, 4'hF, 4'h0});
    tick();
    tick();
    s_ack_i = 3'b010;
    s_dat_i = {32'h0, 32'h1111_2222, 32'h0};
    tick();
    s_ack_i = '0;
    chk("wr_ack", {m_ack_o, m_err_o}, 2'b10);
    chk("wr_cyc_drop", s_cyc_o, '0);
    drop();
    tick();
    chk("wr_ack_pulse", m_ack_o, 1'b0);

    // Read from slave 2, acked on the first strobed cycle
    req(32'h0000_2010, 32'h0, 1'b0);
    tick();
    s_ack_i = 3'b100;
    s_dat_i = {32'hDEAD_BEEF, 32'h0, 32'h0};
    tick();
    s_ack_i = '0;
    chk("rd_ack", {m_ack_o, m_err_o}, 2'b10);
    chk("rd_dat", m_dat_o, 32'hDEAD_BEEF);
    drop();
    tick();

    // Unmapped slot 3
    req(32'h0000_3000, 32'h0, 1'b0);
    tick();
    chk("um_err", {m_ack_o, m_err_o}, 2'b01);
    chk("um_stb", s_stb_o, '0);
    chk("um_dat", m_dat_o, '0);
    drop();
    tick();
    chk("um_pulse", m_err_o, 1'b0);

    // Slave 2 never acks: timeout
    req(32'h0000_2000, 32'h0, 1'b0);
    tick();
    stb_cnt = 0;
    for (int i = 0; i < 20 && !m_err_o; i++) begin
      if (s_stb_o[2]) stb_cnt++;
      tick();
    end
    chk("to_stb_cycles", stb_cnt, 8);
    chk("to_err", {m_ack_o, m_err_o}, 2'b01);
    drop();
    tick();
    req(32'h0000_0000, 32'h0, 1'b0);
    tick();
    s_ack_i = 3'b001;
    s_dat_i = {32'h0, 32'h0, 32'h0BAD_F00D};
    tick();
    s_ack_i = '0;
    chk("to_next_ack", {m_ack_o, m_err_o}, 2'b10);
    chk("to_next_dat", m_dat_o, 32'h0BAD_F00D);
    drop();
    tick();

    // Abort with a simultaneous ack
    req(32'h0000_0040, 32'h1234_5678, 1'b1);
    tick();
    tick();
    m_stb   = 1'b0;
    s_ack_i = 3'b001;
    tick();
    s_ack_i = '0;
    chk("ab_resp", {m_ack_o, m_err_o}, 2'b00);
    chk("ab_cyc", s_cyc_o, '0);
    tick();
    chk("ab_resp2", {m_ack_o, m_err_o}, 2'b00);
    req(32'h0000_2004, 32'hCAFE_0001, 1'b1);
    tick();
    chk("ab_next_cyc", s_cyc_o, 3'b100);
    s_ack_i = 3'b100;
    tick();
    s_ack_i = '0;
    chk("ab_next_ack", m_ack_o, 1'b1);
    drop();
    tick();

    // Asynchronous reset in the middle of a request
    req(32'h0000_1000, 32'h5555_AAAA, 1'b1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_scyc", {s_cyc_o, s_stb_o, s_we_o}, '0);
    chk("ar_sbus", {s_dat_o, s_adr_o, s_sel_o}, '0);
    chk("ar_m", {m_dat_o, m_ack_o, m_err_o}, '0);
    model_reset();
    drop();
    tick();
    rst_n = 1'b1;
    tick();
    req(32'h0000_0000, 32'h0, 1'b0);
    tick();
    s_ack_i = 3'b001;
    s_dat_i = {32'h0, 32'h0, 32'h7777_0001};
    tick();
    s_ack_i = '0;
    chk("ar_rd_ack", m_ack_o, 1'b1);
    chk("ar_rd_dat", m_dat_o, 32'h7777_0001);
    drop();
    tick();

    // Randomized traffic: first busy slaves with frequent aborts, then slow slaves
    for (int i = 0; i < 3000; i++) begin
      int ack_mod, drop_mod;
      ack_mod  = (i < 1500) ? 4 : 16;
      drop_mod = (i < 1500) ? 8 : 64;
      m_cyc = ($urandom % drop_mod) != 0;
      m_stb = ($urandom % drop_mod) != 0;
      m_adr = $urandom;
      m_dat = $urandom;
      m_sel = 4'($urandom);
      m_we  = 1'($urandom);
      for (int k = 0; k < int'(NS); k++) begin
        s_ack_i[k]          = ($urandom % ack_mod) == 0;
        s_dat_i[k*DW +: DW] = $urandom;
      end
      tick();
    end

    drop();
    s_ack_i = '0;
    repeat (3) tick();
    @(negedge clk_i);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
